// File: rtl/alu_cmd_sequencer_if.sv
// Bundles the command, ALU-drive and result channels of the ALU command sequencer.
// The master side is the environment: the producer, the ALU and the consumer.
interface alu_cmd_sequencer_if #(
   parameter int DW = 8,
   parameter int CW = 8
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [DW-1:0] cmd_a;
   logic [DW-1:0] cmd_b;
   logic [2:0]    cmd_sel;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [2:0]    alu_sel;
   logic [DW-1:0] alu_y;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic [2:0]    res_sel;
   logic [CW-1:0] res_count;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_y, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel, res_count
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_y, res_ready,
      output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel, res_count
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a small FIFO, drives them one at a time onto registered
// ALU operands, and captures each ALU result for a valid/ready consumer.
module alu_cmd_sequencer #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input logic                clk,
   input logic                rst_n,
   alu_cmd_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2 * DW + 3;

   typedef enum logic [1:0] {IDLE, DRIVE, RESULT} state_t;

   state_t        state;
   state_t        next_state;
   logic [EW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          res_accept;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [2:0]    alu_sel;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic [2:0]    res_sel;
   logic [CW-1:0] res_count;

   // The extra pointer MSB tells a full FIFO apart from an empty one.
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push       = bus.cmd_valid && !full;
   assign res_accept = res_valid && bus.res_ready;

   assign bus.cmd_ready = !full;
   assign bus.alu_a     = alu_a;
   assign bus.alu_b     = alu_b;
   assign bus.alu_sel   = alu_sel;
   assign bus.res_valid = res_valid;
   assign bus.res_data  = res_data;
   assign bus.res_sel   = res_sel;
   assign bus.res_count = res_count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {bus.cmd_sel, bus.cmd_b, bus.cmd_a};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // A new command is only issued once the previous result has been handed off.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               next_state = DRIVE;
            end
         end
         DRIVE: next_state = RESULT;
         RESULT: begin
            if (res_accept) begin
               if (!empty) begin
                  pop        = 1'b1;
                  next_state = DRIVE;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_sel   <= '0;
         res_count <= '0;
      end else begin
         if (pop) begin
            {alu_sel, alu_b, alu_a} <= mem[rd_ptr[AW-1:0]];
         end
         // The ALU has had a full cycle of stable operands by the end of DRIVE.
         if (state == DRIVE) begin
            res_data  <= bus.alu_y;
            res_sel   <= alu_sel;
            res_valid <= 1'b1;
         end else if (res_accept) begin
            res_valid <= 1'b0;
            res_count <= res_count + 1'b1;
         end
      end
   end
endmodule
